// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants and types for the binary16 add/sub back end.
//   EXP_W / MANT_W : exponent field width / mantissa width incl. hidden bit
//   BIAS, EXP_MAX  : binary16 exponent bias and the all-ones (Inf/NaN) code
//   state_t        : normalizer FSM states
//   RES_*          : bit positions of the packed {sign, exp, frac} result
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int MANT_W  = 11;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam int RES_W       = 16;
  localparam int RES_SIGN    = 15;
  localparam int RES_EXP_HI  = 14;
  localparam int RES_EXP_LO  = 10;
  localparam int RES_FRAC_HI = 9;
  localparam int RES_FRAC_LO = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_round_rne.sv
// fp16_round_rne: combinational round-to-nearest-even increment.
//   mant     in  MANT_W  mantissa to round (carry position already folded)
//   g, r, s  in  1       guard, round, sticky below the mantissa LSB
//   mant_rnd out MANT_W  rounded mantissa (low bits of the sum)
//   carry    out 1       rounding overflowed out of the mantissa
module fp16_round_rne
  import fp16_pkg::*;
#(
  parameter int MANT_W = fp16_pkg::MANT_W
) (
  input  logic [MANT_W-1:0] mant,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  output logic [MANT_W-1:0] mant_rnd,
  output logic              carry
);

  logic round_up;

  // Above half always rounds up; an exact tie rounds up only from an odd LSB.
  assign round_up = g & (r | s | mant[0]);

  assign {carry, mant_rnd} = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};

endmodule

// File: rtl/fp16_normalizer.sv
// fp16_normalizer: normalize / round (RNE) / pack stage of the binary16 adder.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for one operand bundle
//   mant_in[11:0]       raw mantissa, bit 11 = carry, bit 10 = hidden position
//   exp_in, grs_in      biased common exponent, guard/round/sticky
//   sign_in, op_in      result sign, 1 = effective subtraction
//   out_valid/out_ready output handshake
//   result[15:0]        packed {sign, exp, frac}
//   flag_ovf/unf/zero   overflow to Inf, subnormal or flushed, result is +/-0
// Build option: define FP16_NORM_FTZ_EN to flush subnormal results to zero.
module fp16_normalizer
  import fp16_pkg::*;
#(
  parameter int MANT_W = fp16_pkg::MANT_W,
  parameter int EXP_W  = fp16_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W:0]   mant_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [2:0]        grs_in,
  input  logic              sign_in,
  input  logic              op_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              flag_ovf,
  output logic              flag_unf,
  output logic              flag_zero
);

  // One extra exponent bit: the carry shift plus a rounding carry can push
  // the exponent past the field's range before the overflow check.
  localparam int IEXP_W = EXP_W + 1;

  state_t state_reg, state_next;

  logic [MANT_W:0]      mant_reg;
  logic [IEXP_W-1:0]    exp_reg;
  logic                 g_reg, r_reg, s_reg;
  logic                 sign_reg, op_reg;
  logic [RES_W-1:0]     result_reg;
  logic                 flag_ovf_reg, flag_unf_reg, flag_zero_reg;

  // NORM decode
  logic norm_carry, norm_zero, norm_hidden, norm_floor;
  assign norm_carry  = mant_reg[MANT_W];
  assign norm_zero   = (mant_reg == '0) && !g_reg && !r_reg && !s_reg;
  assign norm_hidden = mant_reg[MANT_W-1];
  assign norm_floor  = (exp_reg <= IEXP_W'(1));

  // Rounding and post-round renormalization
  logic [MANT_W-1:0] mant_rnd, mant_fin;
  logic              rnd_carry;
  logic [IEXP_W-1:0] exp_fin;

  fp16_round_rne #(.MANT_W(MANT_W)) u_round (
    .mant     (mant_reg[MANT_W-1:0]),
    .g        (g_reg),
    .r        (r_reg),
    .s        (s_reg),
    .mant_rnd (mant_rnd),
    .carry    (rnd_carry)
  );

  // A rounding carry can only come from all-ones, so the shifted value is
  // exactly the hidden bit alone.
  assign mant_fin = rnd_carry ? {1'b1, {(MANT_W-1){1'b0}}} : mant_rnd;
  assign exp_fin  = exp_reg + IEXP_W'(rnd_carry);

  // Packing of the rounded value
  logic [RES_W-1:0] pack_result;
  logic             pack_ovf, pack_unf, pack_zero;

  always_comb begin
    pack_result = '0;
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    pack_zero   = 1'b0;
    pack_result[RES_SIGN] = sign_reg;
    if (exp_fin >= IEXP_W'(EXP_MAX)) begin
      pack_result[RES_EXP_HI:RES_EXP_LO] = '1;
      pack_ovf = 1'b1;
    end else if (!mant_fin[MANT_W-1]) begin
      pack_unf = 1'b1;
`ifdef FP16_NORM_FTZ_EN
      pack_zero = 1'b1;
`else
      pack_result[RES_FRAC_HI:RES_FRAC_LO] = mant_fin[MANT_W-2:0];
      pack_zero = (mant_fin == '0);
`endif
    end else begin
      pack_result[RES_EXP_HI:RES_EXP_LO]   = exp_fin[EXP_W-1:0];
      pack_result[RES_FRAC_HI:RES_FRAC_LO] = mant_fin[MANT_W-2:0];
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (in_valid) state_next = NORM;
      // After a carry shift the hidden bit is set, so the following NORM
      // cycle hands straight over to ROUND.
      NORM: begin
        if (norm_carry)                    state_next = NORM;
        else if (norm_zero)                state_next = DONE;
        else if (norm_hidden || norm_floor) state_next = ROUND;
      end
      ROUND: state_next = DONE;
      DONE:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_reg      <= '0;
      exp_reg       <= '0;
      g_reg         <= 1'b0;
      r_reg         <= 1'b0;
      s_reg         <= 1'b0;
      sign_reg      <= 1'b0;
      op_reg        <= 1'b0;
      result_reg    <= '0;
      flag_ovf_reg  <= 1'b0;
      flag_unf_reg  <= 1'b0;
      flag_zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            mant_reg      <= mant_in;
            exp_reg       <= {1'b0, exp_in};
            g_reg         <= grs_in[2];
            r_reg         <= grs_in[1];
            s_reg         <= grs_in[0];
            sign_reg      <= sign_in;
            op_reg        <= op_in;
            flag_ovf_reg  <= 1'b0;
            flag_unf_reg  <= 1'b0;
            flag_zero_reg <= 1'b0;
          end
        end
        NORM: begin
          if (norm_carry) begin
            mant_reg <= mant_reg >> 1;
            exp_reg  <= exp_reg + IEXP_W'(1);
            g_reg    <= mant_reg[0];
            r_reg    <= g_reg;
            s_reg    <= s_reg | r_reg;
          end else if (norm_zero) begin
            // x - x yields +0 under round-to-nearest; a true add keeps its sign
            result_reg    <= {sign_reg & ~op_reg, {(RES_W-1){1'b0}}};
            flag_zero_reg <= 1'b1;
          end else if (!norm_hidden && !norm_floor) begin
            mant_reg <= {mant_reg[MANT_W-1:0], g_reg};
            g_reg    <= r_reg;
            r_reg    <= 1'b0;
            exp_reg  <= exp_reg - IEXP_W'(1);
          end
        end
        ROUND: begin
          result_reg    <= pack_result;
          flag_ovf_reg  <= pack_ovf;
          flag_unf_reg  <= pack_unf;
          flag_zero_reg <= pack_zero;
        end
        default: ;
      endcase
    end
  end

  assign result    = result_reg;
  assign flag_ovf  = flag_ovf_reg;
  assign flag_unf  = flag_unf_reg;
  assign flag_zero = flag_zero_reg;

endmodule

// File: tb/tb_fp16_normalizer.sv
// Testbench for fp16_normalizer: directed cases, randomized cases checked
// against a value-level rounding model, backpressure, early out_ready and
// mid-operation reset.
module tb_fp16_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] mant_in;
  logic [4:0]  exp_in;
  logic [2:0]  grs_in;
  logic        sign_in;
  logic        op_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_zero;

  int pass_cnt  = 0;
  int check_cnt = 0;

  fp16_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_in   (mant_in),
    .exp_in    (exp_in),
    .grs_in    (grs_in),
    .sign_in   (sign_in),
    .op_in     (op_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_zero (flag_zero)
  );

  always #5 clk = ~clk;

  // Reference: treat {mant, G, R} as an exact integer v scaled by
  // 2^(exp-27) plus an infinitesimal positive tail when S is set, then round
  // that real value to binary16 with round-to-nearest-even.
  // flg = {ovf, unf, zero}; lat = cycles from accept to out_valid.
  function automatic void ref_model(input logic [11:0] m, input logic [4:0] e,
                                    input logic [2:0] grs, input logic sg,
                                    input logic op, output logic [15:0] res,
                                    output logic [2:0] flg, output int lat);
    int v, ei, p, lsb, q, rem, half, eb, shifts;
    bit s, up;
    v  = int'(m) * 4 + int'(grs[2]) * 2 + int'(grs[1]);
    s  = grs[0];
    ei = int'(e);
    res = '0;
    flg = '0;
    q   = 0;
    lsb = 0;
    if (v == 0 && !s) begin
      res = {sg & ~op, 15'b0};
      flg = 3'b001;
      lat = 1;
      return;
    end
    if (v == 0) begin
      lat = 1 + ei;
    end else begin
      p = 0;
      for (int i = 0; i < 14; i++) if (v[i]) p = i;
      lsb = (p - 10 > 3 - ei) ? p - 10 : 3 - ei;
      if (lsb > 0) begin
        q    = v >> lsb;
        rem  = v & ((1 << lsb) - 1);
        half = 1 << (lsb - 1);
        up   = (rem > half) || (rem == half && (s || q[0]));
        q    = q + int'(up);
      end else begin
        q = v << (-lsb);
      end
      if (q == 2048) begin
        q = 1024;
        lsb++;
      end
      shifts = (p < 12) ? ((12 - p < ei - 1) ? 12 - p : ei - 1) : 0;
      lat = 2 + shifts + ((p == 13) ? 1 : 0);
    end
    if (q >= 1024) begin
      eb = lsb + ei - 2;
      if (eb >= 31) begin
        res = {sg, 5'h1F, 10'h000};
        flg = 3'b100;
      end else begin
        res = {sg, eb[4:0], q[9:0]};
      end
    end else begin
`ifdef FP16_NORM_FTZ_EN
      res = {sg, 15'b0};
      flg = 3'b011;
`else
      res = {sg, 5'b0, q[9:0]};
      flg = (q == 0) ? 3'b011 : 3'b010;
`endif
    end
  endfunction

  // Drives one bundle and waits for out_valid; lat is -1 if the block never
  // became ready, 40 if out_valid never arrived.
  task automatic drive_txn(input logic [11:0] m, input logic [4:0] e,
                           input logic [2:0] grs, input logic sg, input logic op,
                           output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      lat = -1;
      return;
    end
    mant_in  = m;
    exp_in   = e;
    grs_in   = grs;
    sign_in  = sg;
    op_in    = op;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mant_in = '0; exp_in = '0; grs_in = '0; sign_in = 1'b0; op_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_handshake: got %b expected 10", {in_ready, out_valid});
    else pass_cnt++;
    check_cnt++;
    if ({result, flag_ovf, flag_unf, flag_zero} !== 19'h0)
      $display("FAIL reset_outputs: got %h expected 0", {result, flag_ovf, flag_unf, flag_zero});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got %b expected 10", {in_ready, out_valid});
    else pass_cnt++;
  endtask

  typedef struct {
    logic [11:0] m;
    logic [4:0]  e;
    logic [2:0]  grs;
    logic        sg;
    logic        op;
    logic [15:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v [7];
    int lat;
    v[0] = '{12'h800, 5'd15, 3'b000, 1'b0, 1'b0, 16'h4000, 3'b000, 3};
    v[1] = '{12'h001, 5'd15, 3'b000, 1'b1, 1'b1, 16'h9400, 3'b000, 12};
    v[2] = '{12'h000, 5'd15, 3'b000, 1'b1, 1'b1, 16'h0000, 3'b001, 1};
    v[3] = '{12'h000, 5'd9,  3'b000, 1'b1, 1'b0, 16'h8000, 3'b001, 1};
    v[4] = '{12'h7FF, 5'd15, 3'b100, 1'b0, 1'b0, 16'h4000, 3'b000, 2};
    v[5] = '{12'hFFF, 5'd30, 3'b000, 1'b0, 1'b0, 16'h7C00, 3'b100, 3};
`ifdef FP16_NORM_FTZ_EN
    v[6] = '{12'h010, 5'd3,  3'b000, 1'b0, 1'b0, 16'h0000, 3'b011, 4};
`else
    v[6] = '{12'h010, 5'd3,  3'b000, 1'b0, 1'b0, 16'h0040, 3'b010, 4};
`endif
    for (int i = 0; i < 7; i++) begin
      drive_txn(v[i].m, v[i].e, v[i].grs, v[i].sg, v[i].op, lat);
      $display("directed %0d: mant=%h exp=%0d grs=%b -> result=%h flags=%b lat=%0d",
               i, v[i].m, v[i].e, v[i].grs, result, {flag_ovf, flag_unf, flag_zero}, lat);
      check_cnt++;
      if (result !== v[i].res)
        $display("FAIL directed_result[%0d]: got %h expected %h", i, result, v[i].res);
      else pass_cnt++;
      check_cnt++;
      if ({flag_ovf, flag_unf, flag_zero} !== v[i].flg)
        $display("FAIL directed_flags[%0d]: got %b expected %b", i, {flag_ovf, flag_unf, flag_zero}, v[i].flg);
      else pass_cnt++;
      check_cnt++;
      if (lat != v[i].lat)
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat);
      else pass_cnt++;
      release_result();
    end
  endtask

  task automatic test_random();
    logic [11:0] m;
    logic [4:0]  e;
    logic [2:0]  grs, flg;
    logic        sg, op;
    logic [15:0] res;
    int lat, exp_lat;
    for (int i = 0; i < 150; i++) begin
      m   = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
      e   = 5'($urandom_range(1, 31));
      grs = 3'($urandom_range(0, 7));
      sg  = 1'($urandom_range(0, 1));
      op  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) begin
        m = '0;
        grs = 3'($urandom_range(0, 1));
      end
      ref_model(m, e, grs, sg, op, res, flg, exp_lat);
      drive_txn(m, e, grs, sg, op, lat);
      $display("random %0d: mant=%h exp=%0d grs=%b sign=%b op=%b -> result=%h flags=%b lat=%0d",
               i, m, e, grs, sg, op, result, {flag_ovf, flag_unf, flag_zero}, lat);
      check_cnt++;
      if (result !== res)
        $display("FAIL random_result[%0d]: got %h expected %h", i, result, res);
      else pass_cnt++;
      check_cnt++;
      if ({flag_ovf, flag_unf, flag_zero} !== flg)
        $display("FAIL random_flags[%0d]: got %b expected %b", i, {flag_ovf, flag_unf, flag_zero}, flg);
      else pass_cnt++;
      check_cnt++;
      if (lat != exp_lat)
        $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
      else pass_cnt++;
      release_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    drive_txn(12'h001, 5'd15, 3'b000, 1'b1, 1'b1, lat);
    $display("backpressure: result=%h lat=%0d", result, lat);
    for (int c = 0; c < 5; c++) begin
      check_cnt++;
      if ({out_valid, in_ready, result} !== {2'b10, 16'h9400})
        $display("FAIL backpressure_hold[%0d]: got %b/%b/%h expected 1/0/9400", c, out_valid, in_ready, result);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    release_result();
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL backpressure_release: got %b expected 01", {out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_early_ready();
    int lat;
    out_ready = 1'b1;
    drive_txn(12'h800, 5'd15, 3'b000, 1'b0, 1'b0, lat);
    $display("early_ready: result=%h lat=%0d", result, lat);
    check_cnt++;
    if (lat != 3 || result !== 16'h4000)
      $display("FAIL early_ready_result: got lat=%0d %h expected lat=3 4000", lat, result);
    else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL early_ready_accept: got %b expected 01", {out_valid, in_ready});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    while (!in_ready) begin
      @(posedge clk); #1;
    end
    mant_in = 12'h001; exp_in = 5'd15; grs_in = 3'b000; sign_in = 1'b1; op_in = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_cnt++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL reset_mid_async: got %b expected 01", {out_valid, in_ready});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_cnt++;
    if ({out_valid, in_ready, result} !== {2'b01, 16'h0000})
      $display("FAIL reset_mid_next: got %b/%b/%h expected 0/1/0000", out_valid, in_ready, result);
    else pass_cnt++;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    $display("reset_mid: stray out_valid cycles=%0d", n);
    check_cnt++;
    if (n != 0)
      $display("FAIL reset_mid_discard: got %0d valid cycles expected 0", n);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_early_ready();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
